// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/busy/done handshake and operand/result bus for serial_subtractor.
// Carries the ovf flag only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(parameter int WIDTH = 8);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow_out;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf;
   modport master (output start, a, b, input busy, done, diff, borrow_out, ovf);
   modport slave  (input start, a, b, output busy, done, diff, borrow_out, ovf);
`else
   modport master (output start, a, b, input busy, done, diff, borrow_out);
   modport slave  (input start, a, b, output busy, done, diff, borrow_out);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial LSB-first A-B through one full-subtractor cell and a registered borrow.
// Define SERIAL_SUB_OVF_EN to add the two's-complement overflow flag ovf.
module serial_subtractor #(parameter int WIDTH = 8) (
   input  logic               clk,
   input  logic               rst,
   serial_subtractor_if.slave s
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, w_q, w_d, diff_q, diff_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             bin_q, bin_d, bout_q, bout_d;
   logic             d, bnext, load, sh, last;
`ifdef SERIAL_SUB_OVF_EN
   logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d, ovf_q, ovf_d;
`endif
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end
   always_comb begin
      state_d = state_q == IDLE  ? (s.start ? SHIFT : IDLE) :
                state_q == SHIFT ? (last ? DONE : SHIFT) : IDLE;
   end
   always_comb begin
      s.busy       = state_q == SHIFT;
      s.done       = state_q == DONE;
      s.diff       = diff_q;
      s.borrow_out = bout_q;
`ifdef SERIAL_SUB_OVF_EN
      s.ovf        = ovf_q;
`endif
   end
   always_comb begin
      d      = a_q[0] ^ b_q[0] ^ bin_q;
      bnext  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bin_q);
      load   = state_q == IDLE && s.start;
      sh     = state_q == SHIFT;
      last   = sh && cnt_q == CW'(WIDTH - 1);
      a_d    = load ? s.a : sh ? a_q >> 1 : a_q;
      b_d    = load ? s.b : sh ? b_q >> 1 : b_q;
      w_d    = load ? '0 : sh ? {d, w_q[WIDTH-1:1]} : w_q;
      bin_d  = load ? 1'b0 : sh ? bnext : bin_q;
      cnt_d  = load ? '0 : sh ? cnt_q + 1'b1 : cnt_q;
      // Visible result only moves on the final bit, so it holds steady throughout SHIFT.
      diff_d = last ? {d, w_q[WIDTH-1:1]} : diff_q;
      bout_d = last ? bnext : bout_q;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_d = load ? s.a[WIDTH-1] : a_msb_q;
      b_msb_d = load ? s.b[WIDTH-1] : b_msb_q;
      ovf_d   = last ? (a_msb_q != b_msb_q) && (d != a_msb_q) : ovf_q;
`endif
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q    <= '0;
         b_q    <= '0;
         w_q    <= '0;
         diff_q <= '0;
         cnt_q  <= '0;
         bin_q  <= 1'b0;
         bout_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         ovf_q   <= 1'b0;
`endif
      end else begin
         a_q    <= a_d;
         b_q    <= b_d;
         w_q    <= w_d;
         diff_q <= diff_d;
         cnt_q  <= cnt_d;
         bin_q  <= bin_d;
         bout_q <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
         a_msb_q <= a_msb_d;
         b_msb_q <= b_msb_d;
         ovf_q   <= ovf_d;
`endif
      end
   end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed vectors for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;
   localparam int W = 8;
   logic clk = 1'b0;
   logic rst;
   int   vectors = 0;
   int   miscompares = 0;
   serial_subtractor_if #(.WIDTH(W)) sif();
   serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .s(sif));
   always #5 clk = ~clk;
   task automatic do_op(input logic [7:0] av, input logic [7:0] bv, output int lat, output int bcnt,
                        output int dcnt, output logic [7:0] dv, output logic bo, output logic early);
      logic [7:0] prev;
      lat = -1; bcnt = 0; dcnt = 0; early = 1'b0;
      prev = sif.diff;
      @(posedge clk); #1;
      sif.a = av; sif.b = bv; sif.start = 1'b1;
      @(posedge clk); #1;
      sif.start = 1'b0; sif.a = '1; sif.b = '1;
      for (int i = 0; i < W + 6; i++) begin
         if (sif.busy) begin
            bcnt++;
            if (sif.diff !== prev) early = 1'b1;
         end
         if (sif.done) begin
            dcnt++;
            if (lat < 0) lat = i;
         end
         @(posedge clk); #1;
      end
      dv = sif.diff;
      bo = sif.borrow_out;
   endtask
   task automatic test_reset;
      rst = 1'b1; sif.start = 1'b0; sif.a = 8'h5A; sif.b = 8'hA5;
      repeat (2) @(posedge clk);
      #1;
      vectors++; if (sif.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", sif.busy); end
      vectors++; if (sif.done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", sif.done); end
      vectors++; if (sif.diff !== 8'h00) begin miscompares++; $display("FAIL reset_diff got %h want 00", sif.diff); end
      vectors++; if (sif.borrow_out !== 1'b0) begin miscompares++; $display("FAIL reset_borrow got %b want 0", sif.borrow_out); end
      rst = 1'b0;
   endtask
   task automatic test_op(input string nm, input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] ed, input logic eb, input logic eo);
      int lat, bcnt, dcnt;
      logic [7:0] dv;
      logic bo, early;
      do_op(av, bv, lat, bcnt, dcnt, dv, bo, early);
      vectors++; if (dv !== ed) begin miscompares++; $display("FAIL %s_diff got %h want %h", nm, dv, ed); end
      vectors++; if (bo !== eb) begin miscompares++; $display("FAIL %s_borrow got %b want %b", nm, bo, eb); end
      vectors++; if (lat !== W) begin miscompares++; $display("FAIL %s_latency got %0d want %0d", nm, lat, W); end
      vectors++; if (bcnt !== W) begin miscompares++; $display("FAIL %s_busy_cycles got %0d want %0d", nm, bcnt, W); end
      vectors++; if (dcnt !== 1) begin miscompares++; $display("FAIL %s_done_pulses got %0d want 1", nm, dcnt); end
      vectors++; if (early !== 1'b0) begin miscompares++; $display("FAIL %s_diff_moved_in_shift got %b want 0", nm, early); end
`ifdef SERIAL_SUB_OVF_EN
      vectors++; if (sif.ovf !== eo) begin miscompares++; $display("FAIL %s_ovf got %b want %b", nm, sif.ovf, eo); end
`else
      if (eo === 1'bx) $display("note: unexpected x ovf expectation in %s", nm);
`endif
   endtask
   task automatic test_basic;
      test_op("basic", 8'h35, 8'h12, 8'h23, 1'b0, 1'b0);
   endtask
   task automatic test_underflow;
      test_op("under1", 8'h12, 8'h35, 8'hDD, 1'b1, 1'b0);
      test_op("under2", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
      test_op("equal", 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);
   endtask
   task automatic test_signed;
      test_op("ovf_pos", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
      test_op("ovf_neg", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
      test_op("noovf", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
   endtask
   task automatic test_ignored_start;
      int bcnt = 0, dcnt = 0;
      @(posedge clk); #1;
      sif.a = 8'h35; sif.b = 8'h12; sif.start = 1'b1;
      @(posedge clk); #1;
      sif.start = 1'b0;
      for (int i = 0; i < W + 8; i++) begin
         if (sif.busy) bcnt++;
         if (sif.done) dcnt++;
         if (i == 2) begin sif.a = 8'hFF; sif.b = 8'h00; sif.start = 1'b1; end
         if (i == 3) sif.start = 1'b0;
         if (i == W) begin sif.a = 8'hFF; sif.b = 8'h00; sif.start = 1'b1; end
         if (i == W + 1) sif.start = 1'b0;
         @(posedge clk); #1;
      end
      vectors++; if (sif.diff !== 8'h23) begin miscompares++; $display("FAIL ign_diff got %h want 23", sif.diff); end
      vectors++; if (sif.borrow_out !== 1'b0) begin miscompares++; $display("FAIL ign_borrow got %b want 0", sif.borrow_out); end
      vectors++; if (dcnt !== 1) begin miscompares++; $display("FAIL ign_done_pulses got %0d want 1", dcnt); end
      vectors++; if (bcnt !== W) begin miscompares++; $display("FAIL ign_busy_cycles got %0d want %0d", bcnt, W); end
   endtask
   task automatic test_reset_mid;
      int dcnt = 0, bcnt = 0, lat, bc2, dc2;
      logic [7:0] dv;
      logic bo, early;
      @(posedge clk); #1;
      sif.a = 8'hAA; sif.b = 8'h55; sif.start = 1'b1;
      @(posedge clk); #1;
      sif.start = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1; sif.start = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; sif.start = 1'b0;
      vectors++; if (sif.busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy got %b want 0", sif.busy); end
      vectors++; if (sif.done !== 1'b0) begin miscompares++; $display("FAIL rstmid_done got %b want 0", sif.done); end
      vectors++; if (sif.diff !== 8'h00) begin miscompares++; $display("FAIL rstmid_diff got %h want 00", sif.diff); end
      vectors++; if (sif.borrow_out !== 1'b0) begin miscompares++; $display("FAIL rstmid_borrow got %b want 0", sif.borrow_out); end
      for (int i = 0; i < 12; i++) begin
         if (sif.done) dcnt++;
         if (sif.busy) bcnt++;
         @(posedge clk); #1;
      end
      vectors++; if (dcnt !== 0) begin miscompares++; $display("FAIL rstmid_stray_done got %0d want 0", dcnt); end
      vectors++; if (bcnt !== 0) begin miscompares++; $display("FAIL rstmid_stray_busy got %0d want 0", bcnt); end
      do_op(8'hAA, 8'h55, lat, bc2, dc2, dv, bo, early);
      vectors++; if (dv !== 8'h55) begin miscompares++; $display("FAIL fresh_diff got %h want 55", dv); end
      vectors++; if (bo !== 1'b0) begin miscompares++; $display("FAIL fresh_borrow got %b want 0", bo); end
      vectors++; if (dc2 !== 1) begin miscompares++; $display("FAIL fresh_done_pulses got %0d want 1", dc2); end
      vectors++; if (lat !== W) begin miscompares++; $display("FAIL fresh_latency got %0d want %0d", lat, W); end
   endtask
   initial begin
      test_reset();
      test_basic();
      test_underflow();
      test_signed();
      test_ignored_start();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
